hazard_ctrl: RTL and testbench

Hazard and stall sequencer for the 16-bit five-stage pipeline. It reads the ID/EX register outputs (destination register, memory-op code) and the EX/MEM memory request. It drives the idClear bubble input of the ID/EX register and the hold/flush controls of the PC and the IF/ID register. It covers load-use hazards, the instruction-RAM structural hazard, and taken-branch flushes, and it keeps a saturating stall counter for debug.

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 29 ++
 rtl/hazard_ctrl_detect.sv | 23 ++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings for the hazard/stall sequencer
package hazard_ctrl_pkg;

    typedef logic [3:0] reg_idx_t;
    typedef logic [1:0] mem_op_t;

    localparam reg_idx_t REG_NONE  = 4'b1111;
    localparam mem_op_t  MEM_LOAD  = 2'b00;
    localparam mem_op_t  MEM_STORE = 2'b01;
    localparam mem_op_t  MEM_NONE  = 2'b11;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_IMEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH     = 2'd2;

    function automatic logic is_mem_access(input mem_op_t op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signals seen and driven by the hazard sequencer
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    reg_idx_t    ex_wreg;
    mem_op_t     ex_controlmem;
    reg_idx_t    id_rreg1;
    reg_idx_t    id_rreg2;
    logic        ex_ifjump;
    mem_op_t     mem_controlmem;
    logic [15:0] mem_addr;
    logic        idClear;
    logic        pc_hold;
    logic        ifid_hold;
    logic        ifid_flush;
    logic [15:0] stall_cnt;

    modport master (
        output ex_wreg, ex_controlmem, id_rreg1, id_rreg2, ex_ifjump,
               mem_controlmem, mem_addr,
        input  idClear, pc_hold, ifid_hold, ifid_flush, stall_cnt
    );

    modport slave (
        input  ex_wreg, ex_controlmem, id_rreg1, id_rreg2, ex_ifjump,
               mem_controlmem, mem_addr,
        output idClear, pc_hold, ifid_hold, ifid_flush, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// rtl/hazard_ctrl_detect.sv - combinational load-use and instruction-RAM conflict detection
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter logic [15:0] IMEM_LIMIT = 16'h8000
) (
    input  reg_idx_t    ex_wreg,
    input  mem_op_t     ex_controlmem,
    input  reg_idx_t    id_rreg1,
    input  reg_idx_t    id_rreg2,
    input  mem_op_t     mem_controlmem,
    input  logic [15:0] mem_addr,
    output logic        load_use,
    output logic        imem_hit
);

    // An unused source (REG_NONE) cannot match because a real destination is never REG_NONE.
    assign load_use = (ex_controlmem == MEM_LOAD) && (ex_wreg != REG_NONE) &&
                      ((ex_wreg == id_rreg1) || (ex_wreg == id_rreg2));

    assign imem_hit = is_mem_access(mem_controlmem) && (mem_addr < IMEM_LIMIT);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencer for load-use, instruction-RAM and branch hazards
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter logic [15:0] IMEM_LIMIT = 16'h8000,
    parameter int          MEM_WAIT   = 2,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

    logic       load_use, imem_hit;
    logic [1:0] state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       clr_c, pch_c, hold_c, flush_c;
    logic [15:0] cnt_q;

    hazard_detect #(.IMEM_LIMIT(IMEM_LIMIT)) u_detect (
        .ex_wreg        (hz.ex_wreg),
        .ex_controlmem  (hz.ex_controlmem),
        .id_rreg1       (hz.id_rreg1),
        .id_rreg2       (hz.id_rreg2),
        .mem_controlmem (hz.mem_controlmem),
        .mem_addr       (hz.mem_addr),
        .load_use       (load_use),
        .imem_hit       (imem_hit)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        clr_c   = 1'b0;
        pch_c   = 1'b0;
        hold_c  = 1'b0;
        flush_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (imem_hit) begin
                    pch_c   = 1'b1;
                    flush_c = 1'b1;
                    if (MEM_WAIT > 1) begin
                        state_d = ST_IMEM_WAIT;
                        wait_d  = WAIT_INIT;
                    end
                end else if (hz.ex_ifjump && !DELAY_SLOT) begin
                    flush_c = 1'b1;
                    clr_c   = 1'b1;
                    state_d = ST_FLUSH;
                end else if (load_use) begin
                    pch_c  = 1'b1;
                    hold_c = 1'b1;
                    clr_c  = 1'b1;
                end
            end
            ST_IMEM_WAIT: begin
                // A branch here is ignored: its target already sits in the held PC.
                pch_c   = 1'b1;
                flush_c = 1'b1;
                if (load_use) begin
                    clr_c  = 1'b1;
                    hold_c = 1'b1;
                end
                wait_d = 3'(wait_q - 3'd1);
                if (wait_q == 3'd1) state_d = ST_RUN;
            end
            ST_FLUSH: begin
                clr_c   = 1'b1;
                flush_c = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            wait_q  <= 3'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (pch_c && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
        end
    end

    // Outputs are gated by reset so an asynchronous reset silences them at once.
    assign hz.idClear    = rst & clr_c;
    assign hz.pc_hold    = rst & pch_c;
    assign hz.ifid_hold  = rst & hold_c;
    assign hz.ifid_flush = rst & flush_c & ~hold_c;
    assign hz.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed check of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int          MW  = 2;
    localparam logic [15:0] LIM = 16'h8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  ex_wreg, id_rreg1, id_rreg2;
    logic [1:0]  ex_cm, mem_cm;
    logic        ex_ifjump;
    logic [15:0] mem_addr;

    hazard_ctrl_if hz0 ();
    hazard_ctrl_if hz1 ();

    assign hz0.ex_wreg = ex_wreg;   assign hz1.ex_wreg = ex_wreg;
    assign hz0.ex_controlmem = ex_cm;  assign hz1.ex_controlmem = ex_cm;
    assign hz0.id_rreg1 = id_rreg1; assign hz1.id_rreg1 = id_rreg1;
    assign hz0.id_rreg2 = id_rreg2; assign hz1.id_rreg2 = id_rreg2;
    assign hz0.ex_ifjump = ex_ifjump; assign hz1.ex_ifjump = ex_ifjump;
    assign hz0.mem_controlmem = mem_cm; assign hz1.mem_controlmem = mem_cm;
    assign hz0.mem_addr = mem_addr; assign hz1.mem_addr = mem_addr;

    hazard_ctrl #(.IMEM_LIMIT(LIM), .MEM_WAIT(MW), .DELAY_SLOT(1'b0)) dut0 (
        .clk (clk), .rst (rst), .hz (hz0)
    );
    hazard_ctrl #(.IMEM_LIMIT(LIM), .MEM_WAIT(MW), .DELAY_SLOT(1'b1)) dut1 (
        .clk (clk), .rst (rst), .hz (hz1)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model state per DUT: remaining frozen fetch cycles, pending second flush, stall count.
    int freeze_left[2];
    bit flush_pend[2];
    int mcnt[2];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ex_wreg = 4'hF; id_rreg1 = 4'hF; id_rreg2 = 4'hF;
        ex_cm = 2'b11; mem_cm = 2'b11; ex_ifjump = 1'b0; mem_addr = 16'hFFFF;
    endtask

    task automatic rand_in();
        ex_wreg  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
        id_rreg1 = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
        id_rreg2 = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
        ex_cm    = 2'($urandom_range(0, 3));
        mem_cm   = 2'($urandom_range(0, 3));
        ex_ifjump = ($urandom_range(0, 7) == 0);
        mem_addr = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
    endtask

    // Called at a negedge with inputs applied; checks outputs, advances the model, waits a cycle.
    task automatic step();
        logic [3:0]  got[2];
        logic [15:0] gcnt[2];
        #2;
        got[0]  = {hz0.idClear, hz0.pc_hold, hz0.ifid_hold, hz0.ifid_flush};
        got[1]  = {hz1.idClear, hz1.pc_hold, hz1.ifid_hold, hz1.ifid_flush};
        gcnt[0] = hz0.stall_cnt;
        gcnt[1] = hz1.stall_cnt;
        for (int d = 0; d < 2; d++) begin
            logic lu, hit, ic, ph, ih, fl;
            lu  = (ex_cm == 2'b00) && (ex_wreg != 4'hF) &&
                  ((ex_wreg == id_rreg1) || (ex_wreg == id_rreg2));
            hit = ((mem_cm == 2'b00) || (mem_cm == 2'b01)) && (mem_addr < LIM);
            ic = 0; ph = 0; ih = 0; fl = 0;
            if (!rst) begin
                freeze_left[d] = 0; flush_pend[d] = 0; mcnt[d] = 0;
            end else if (freeze_left[d] > 0) begin
                ph = 1;
                if (lu) begin ic = 1; ih = 1; end else fl = 1;
                freeze_left[d]--;
            end else if (flush_pend[d]) begin
                ic = 1; fl = 1; flush_pend[d] = 0;
            end else if (hit) begin
                ph = 1; fl = 1; freeze_left[d] = MW - 1;
            end else if (ex_ifjump && d == 0) begin
                ic = 1; fl = 1; flush_pend[d] = 1;
            end else if (lu) begin
                ph = 1; ih = 1; ic = 1;
            end
            check(d == 0 ? "ctl_ds0" : "ctl_ds1", {12'd0, got[d]}, {12'd0, ic, ph, ih, fl});
            check(d == 0 ? "cnt_ds0" : "cnt_ds1", gcnt[d], 16'(mcnt[d]));
            if (rst && ph && mcnt[d] < 65535) mcnt[d]++;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            freeze_left[d] = 0; flush_pend[d] = 0; mcnt[d] = 0;
        end
        rst = 1'b0;
        idle();
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin rand_in(); step(); end
        rst = 1'b1; idle(); step();

        ex_cm = 2'b00; ex_wreg = 4'd3; id_rreg2 = 4'd3; step();
        idle(); step();

        ex_cm = 2'b00; ex_wreg = 4'hF; id_rreg1 = 4'hF; step();
        idle(); ex_cm = 2'b01; ex_wreg = 4'd3; id_rreg1 = 4'd3; step();
        idle(); step();

        mem_cm = 2'b01; mem_addr = 16'h4000; step();
        idle(); step(); step();
        mem_cm = 2'b00; mem_addr = 16'h8000; step();
        idle(); step();

        ex_ifjump = 1'b1; step();
        idle(); step(); step();

        mem_cm = 2'b00; mem_addr = 16'h0010; step();
        idle(); rst = 1'b0; step();
        rst = 1'b1; step(); step();

        for (int i = 0; i < 3000; i++) begin
            rand_in();
            rst = ($urandom_range(0, 63) != 0);
            step();
        end

        rst = 1'b1; idle(); step(); step();
        ex_cm = 2'b00; ex_wreg = 4'd5; id_rreg1 = 4'd5;
        for (int i = 0; i < 65540; i++) step();
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
